// File: rtl/lif_array.sv
// lif_array: N independent leaky integrate-and-fire neurons with a shared
// step enable and a shared threshold/reset-mode configuration.
//
// Each enabled step, a neuron that is not refractory leaks its membrane
// (s >> LEAK_SHIFT), adds its input current with saturation, and fires when
// the result reaches the registered threshold. A neuron that fires then
// ignores its input for REFRAC steps and only leaks.
//
// Optional feature (macro LIF_SPIKE_CNT_EN): per-neuron saturating spike
// counters. This adds the CNT_W parameter, the cnt_clr input and the
// spike_cnt output. When the macro is undefined, those are absent.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         step enable, one integration step per edge with en=1
//   current    N*W per-neuron unsigned input current, neuron i at [i*W +: W]
//   cfg_we     write strobe for cfg_thresh / cfg_mode
//   cfg_thresh new threshold value
//   cfg_mode   post-spike reset: 0 = to zero, 1 = subtract threshold
//   cnt_clr    (LIF_SPIKE_CNT_EN) clear all spike counters
//   spike_cnt  (LIF_SPIKE_CNT_EN) N*CNT_W saturating spike counts
//   state      N*W registered membrane potentials
//   spike      N registered one-cycle spike pulses
//   refrac     N flags, high while a neuron is refractory
module lif_array #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 2
`ifdef LIF_SPIKE_CNT_EN
  ,
  parameter int unsigned CNT_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N*W-1:0]   current,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_thresh,
  input  logic             cfg_mode,
`ifdef LIF_SPIKE_CNT_EN
  input  logic             cnt_clr,
  output logic [N*CNT_W-1:0] spike_cnt,
`endif
  output logic [N*W-1:0]   state,
  output logic [N-1:0]     spike,
  output logic [N-1:0]     refrac
);

  localparam int unsigned RW = (REFRAC == 0) ? 1 : $clog2(REFRAC + 1);
  localparam logic [W-1:0] THRESH_RST = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] thresh_q;
  logic         mode_q;

  // Shared configuration; a write takes effect from the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thresh_q <= THRESH_RST;
      mode_q   <= 1'b0;
    end else if (cfg_we) begin
      thresh_q <= cfg_thresh;
      mode_q   <= cfg_mode;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_neuron
    logic [W-1:0]  s_q;
    logic [RW-1:0] r_q;
    logic          spike_q;
    logic [W-1:0]  leak_c;
    logic [W:0]    sum_c;
    logic [W-1:0]  sat_c;
    logic          fire_c;

    // Leak then integrate in W+1 bits so the carry flags saturation.
    assign leak_c = s_q >> LEAK_SHIFT;
    assign sum_c  = {1'b0, leak_c} + {1'b0, current[g*W +: W]};
    assign sat_c  = sum_c[W] ? {W{1'b1}} : sum_c[W-1:0];
    assign fire_c = (r_q == '0) && (sat_c >= thresh_q);

    // Membrane, refractory counter and spike pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q     <= '0;
        r_q     <= '0;
        spike_q <= 1'b0;
      end else begin
        spike_q <= 1'b0;
        if (en) begin
          if (r_q != '0) begin
            s_q <= leak_c;
            r_q <= r_q - RW'(1);
          end else if (fire_c) begin
            spike_q <= 1'b1;
            r_q     <= RW'(REFRAC);
            // sat_c >= thresh_q here, so the subtraction cannot wrap.
            s_q     <= mode_q ? (sat_c - thresh_q) : '0;
          end else begin
            s_q <= sat_c;
          end
        end
      end
    end

    assign state[g*W +: W] = s_q;
    assign spike[g]        = spike_q;
    assign refrac[g]       = (r_q != '0);

`ifdef LIF_SPIKE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating spike counter; clear wins over a coincident spike.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (en && fire_c && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign spike_cnt[g*CNT_W +: CNT_W] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;

  localparam int unsigned N      = 4;
  localparam int unsigned W      = 8;
  localparam int unsigned LS     = 1;
  localparam int unsigned REFRAC = 2;
`ifdef LIF_SPIKE_CNT_EN
  localparam int unsigned CNT_W  = 2;
`endif
  localparam int MAXV = (1 << W) - 1;

  logic           clk;
  logic           rst;
  logic           en;
  logic [N*W-1:0] current;
  logic           cfg_we;
  logic [W-1:0]   cfg_thresh;
  logic           cfg_mode;
  logic [N*W-1:0] state;
  logic [N-1:0]   spike;
  logic [N-1:0]   refrac;
`ifdef LIF_SPIKE_CNT_EN
  logic               cnt_clr;
  logic [N*CNT_W-1:0] spike_cnt;
`endif

  lif_array #(
    .N(N), .W(W), .LEAK_SHIFT(LS), .REFRAC(REFRAC)
`ifdef LIF_SPIKE_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .current(current),
    .cfg_we(cfg_we),
    .cfg_thresh(cfg_thresh),
    .cfg_mode(cfg_mode),
`ifdef LIF_SPIKE_CNT_EN
    .cnt_clr(cnt_clr),
    .spike_cnt(spike_cnt),
`endif
    .state(state),
    .spike(spike),
    .refrac(refrac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers per neuron.
  int ms[N];
  int mr[N];
  int mspk[N];
  int mcnt[N];
  int mth;
  int mmode;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ms[i] = 0; mr[i] = 0; mspk[i] = 0; mcnt[i] = 0;
    end
    mth = (1 << (W - 1)) - 1;
    mmode = 0;
  endtask

  task automatic model_update(input logic e, input logic [N*W-1:0] cur,
                              input logic we, input logic [W-1:0] th,
                              input logic md, input logic clr);
    int sum;
    int cmax;
`ifdef LIF_SPIKE_CNT_EN
    cmax = (1 << CNT_W) - 1;
`else
    cmax = 255;
`endif
    for (int i = 0; i < N; i++) begin
      mspk[i] = 0;
      if (e) begin
        if (mr[i] > 0) begin
          ms[i] = ms[i] / (1 << LS);
          mr[i] = mr[i] - 1;
        end else begin
          sum = ms[i] / (1 << LS) + int'(cur[i*W +: W]);
          if (sum > MAXV) sum = MAXV;
          if (sum >= mth) begin
            mspk[i] = 1;
            mr[i] = REFRAC;
            ms[i] = (mmode != 0) ? sum - mth : 0;
          end else begin
            ms[i] = sum;
          end
        end
      end
      if (clr) mcnt[i] = 0;
      else if (mspk[i] != 0 && mcnt[i] < cmax) mcnt[i] = mcnt[i] + 1;
    end
    if (we) begin
      mth = int'(th);
      mmode = int'(md);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("state%0d", i), int'(state[i*W +: W]), ms[i]);
      check($sformatf("spike%0d", i), int'(spike[i]), mspk[i]);
      check($sformatf("refrac%0d", i), int'(refrac[i]), (mr[i] != 0) ? 1 : 0);
`ifdef LIF_SPIKE_CNT_EN
      check($sformatf("cnt%0d", i), int'(spike_cnt[i*CNT_W +: CNT_W]), mcnt[i]);
`endif
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare everything.
  task automatic step(input logic e, input logic [N*W-1:0] cur, input logic we,
                      input logic [W-1:0] th, input logic md, input logic clr);
    en = e; current = cur; cfg_we = we; cfg_thresh = th; cfg_mode = md;
`ifdef LIF_SPIKE_CNT_EN
    cnt_clr = clr;
`endif
    @(posedge clk);
    #1;
    model_update(e, cur, we, th, md, clr);
    compare_all();
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic do_reset();
    en = 1'b0; cfg_we = 1'b0;
`ifdef LIF_SPIKE_CNT_EN
    cnt_clr = 1'b0;
`endif
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit rst_before;
    bit e;
    int cur0;
    bit we;
    int th;
    bit md;
    int st;
    bit sp;
    bit rf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rb, input bit e, input int c, input bit we,
                     input int th, input bit md, input int st, input bit sp,
                     input bit rf);
    vec_t v;
    v.rst_before = rb; v.e = e; v.cur0 = c; v.we = we; v.th = th; v.md = md;
    v.st = st; v.sp = sp; v.rf = rf;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] cur;
    rst = 1'b1; en = 1'b0; current = '0; cfg_we = 1'b0;
    cfg_thresh = '0; cfg_mode = 1'b0;
`ifdef LIF_SPIKE_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    #12;
    compare_all();
    #1;
    rst = 1'b0;
    #4;

    // Async reset mid-run: outputs must clear before the next edge.
    cur = '0;
    cur[W-1:0] = W'(100);
    cur[2*W-1:W] = W'(60);
    step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
    check("pre_rst_spike0", int'(spike[0]), 1);
    check("pre_rst_state1", int'(state[2*W-1:W]), 90);
    rst = 1'b1;
    #1;
    check("async_rst_state", (state == '0) ? 1 : 0, 1);
    check("async_rst_spike", int'(spike), 0);
    check("async_rst_refrac", int'(refrac), 0);
    #2;
    rst = 1'b0;
    model_reset();

    // Sub-threshold leak/integrate.
    add(1, 1, 50, 0, 0, 0, 50, 0, 0);
    add(0, 1, 50, 0, 0, 0, 75, 0, 0);
    add(0, 1, 50, 0, 0, 0, 87, 0, 0);
    add(0, 1, 50, 0, 0, 0, 93, 0, 0);
    add(0, 1, 50, 0, 0, 0, 96, 0, 0);
    add(0, 1, 50, 0, 0, 0, 98, 0, 0);
    add(0, 1, 50, 0, 0, 0, 99, 0, 0);
    add(0, 1, 50, 0, 0, 0, 99, 0, 0);
    // Spike and refractory, reset-to-zero mode with default threshold.
    add(1, 1, 100, 0, 0, 0, 100, 0, 0);
    add(0, 1, 100, 0, 0, 0, 0, 1, 1);
    add(0, 1, 100, 0, 0, 0, 0, 0, 1);
    add(0, 1, 100, 0, 0, 0, 0, 0, 0);
    add(0, 1, 100, 0, 0, 0, 100, 0, 0);
    add(0, 1, 100, 0, 0, 0, 0, 1, 1);
    // Saturation and subtract mode.
    add(1, 0, 0, 1, 127, 1, 0, 0, 0);
    add(0, 1, 255, 0, 0, 0, 128, 1, 1);
    add(0, 1, 255, 0, 0, 0, 64, 0, 1);
    add(0, 1, 255, 0, 0, 0, 32, 0, 0);
    add(0, 1, 255, 0, 0, 0, 128, 1, 1);
    // Config write coincident with a step, then en gating.
    add(1, 1, 100, 1, 60, 0, 100, 0, 0);
    add(0, 0, 200, 0, 0, 0, 100, 0, 0);
    add(0, 0, 200, 0, 0, 0, 100, 0, 0);
    add(0, 0, 200, 0, 0, 0, 100, 0, 0);
    add(0, 1, 10, 0, 0, 0, 0, 1, 1);
    add(0, 0, 10, 0, 0, 0, 0, 0, 1);
    // Threshold zero: every non-refractory step fires.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst_before) do_reset();
      cur = '0;
      cur[W-1:0] = W'(tbl[k].cur0);
      step(tbl[k].e, cur, tbl[k].we, W'(tbl[k].th), tbl[k].md, 1'b0);
      check($sformatf("v%0d_state0", k), int'(state[W-1:0]), tbl[k].st);
      check($sformatf("v%0d_spike0", k), int'(spike[0]), int'(tbl[k].sp));
      check($sformatf("v%0d_refrac0", k), int'(refrac[0]), int'(tbl[k].rf));
    end

`ifdef LIF_SPIKE_CNT_EN
    // Counter saturation and clear priority over a coincident spike.
    begin
      int exp_cnt[5] = '{1, 2, 3, 3, 3};
      do_reset();
      cur = '0;
      cur[W-1:0] = W'(255);
      for (int s = 0; s < 5; s++) begin
        step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
        check($sformatf("cnt_spk%0d", s), int'(spike[0]), 1);
        check($sformatf("cnt_val%0d", s), int'(spike_cnt[CNT_W-1:0]), exp_cnt[s]);
        if (s < 4) begin
          step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
          step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
        end
      end
      step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, cur, 1'b0, '0, 1'b0, 1'b1);
      check("cnt_clr_spk", int'(spike[0]), 1);
      check("cnt_clr_val", int'(spike_cnt[CNT_W-1:0]), 0);
    end
`endif

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic e, we, md, clr;
      logic [W-1:0] th;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) cur[i*W +: W] = W'($urandom_range(200, 255));
        else cur[i*W +: W] = W'($urandom_range(0, 80));
      end
      e   = ($urandom_range(0, 7) != 0);
      we  = ($urandom_range(0, 15) == 0);
      th  = W'($urandom_range(0, 255));
      md  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step(e, cur, we, th, md, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
